// File: rtl/dec_chan_sched.sv
// Frame-level channel scheduler for the ADPCM decoder. It walks every channel through
// select / settle / FA handshake / delay strobe, and flags FA timeouts and frame overruns.
//
//   state   | meaning
//   IDLE    | waiting for a frame-start pulse
//   PRE     | channel selected, settle window running
//   TRIG    | one-cycle FA start pulse
//   WAIT_FA | waiting for FA completion, with timeout
//   STRB    | delay strobe and register-file write for the current channel
//   NEXT    | advance to the next channel, or finish the frame
module dec_chan_sched #(
  parameter int NUM_CHAN    = 8,
  parameter int CHN_W       = 3,
  parameter int CNT_PRE_FA  = 125,
  parameter int CNT_POST_FA = 450
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             fs_pulse_i,
  input  logic             fa_done_i,
  output logic             fa_trig_o,
  output logic             dly_strb_o,
  output logic             wr_en_o,
  output logic [CHN_W-1:0] wr_addr_o,
  output logic [CHN_W-1:0] rd_addr_o,
  output logic [CHN_W-1:0] chn_cnt_o,
  output logic             busy_o,
  output logic             error_o
);

  localparam int CNT_MAX = (CNT_PRE_FA > CNT_POST_FA) ? CNT_PRE_FA : CNT_POST_FA;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(CNT_PRE_FA - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(CNT_POST_FA - 1);
  localparam logic [CHN_W-1:0] CHN_LAST  = CHN_W'(NUM_CHAN - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    TRIG    = 3'd2,
    WAIT_FA = 3'd3,
    STRB    = 3'd4,
    NEXT    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CHN_W-1:0] chn_q, chn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             frame_end;
  logic             overrun;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      chn_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chn_q   <= chn_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // A frame start that lands on the final NEXT is a clean back-to-back frame.
  assign frame_end = (state_q == NEXT) && (chn_q == CHN_LAST);
  assign overrun   = fs_pulse_i && (state_q != IDLE) && !frame_end;

  always_comb begin
    state_d = state_q;
    chn_d   = chn_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (overrun) begin
      err_d   = 1'b1;
      state_d = PRE;
      chn_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fs_pulse_i) begin
            state_d = PRE;
            chn_d   = '0;
            cnt_d   = '0;
          end
        end
        PRE: begin
          if (cnt_q == PRE_LAST) begin
            state_d = TRIG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        TRIG: begin
          state_d = WAIT_FA;
          cnt_d   = '0;
        end
        WAIT_FA: begin
          if (fa_done_i) begin
            state_d = STRB;
          end else if (cnt_q == POST_LAST) begin
            err_d   = 1'b1;
            state_d = STRB;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STRB: begin
          state_d = NEXT;
        end
        NEXT: begin
          cnt_d = '0;
          if (chn_q == CHN_LAST) begin
            chn_d   = '0;
            state_d = fs_pulse_i ? PRE : IDLE;
          end else begin
            chn_d   = chn_q + CHN_W'(1);
            state_d = PRE;
          end
        end
        default: begin
          state_d = IDLE;
          chn_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign fa_trig_o  = (state_q == TRIG);
  assign dly_strb_o = (state_q == STRB);
  assign wr_en_o    = (state_q == STRB);
  assign wr_addr_o  = chn_q;
  assign rd_addr_o  = chn_q;
  assign chn_cnt_o  = chn_q;
  assign busy_o     = (state_q != IDLE);
  assign error_o    = err_q;

endmodule

// File: tb/tb_dec_chan_sched.sv
// Bench for dec_chan_sched with 2 channels, 3-cycle settle and 5-cycle FA timeout.
// Expected write addresses are queued as each FA handshake is driven and popped on every strobe.
module tb_dec_chan_sched;
  localparam int NUM_CHAN    = 2;
  localparam int CHN_W       = 1;
  localparam int CNT_PRE_FA  = 3;
  localparam int CNT_POST_FA = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             fs_pulse;
  logic             fa_done;
  logic             fa_trig;
  logic             dly_strb;
  logic             wr_en;
  logic [CHN_W-1:0] wr_addr;
  logic [CHN_W-1:0] rd_addr;
  logic [CHN_W-1:0] chn_cnt;
  logic             busy;
  logic             error;

  int total = 0;
  int bad   = 0;
  int exp_err = 0;
  int exp_addr_q[$];

  dec_chan_sched #(
    .NUM_CHAN(NUM_CHAN), .CHN_W(CHN_W),
    .CNT_PRE_FA(CNT_PRE_FA), .CNT_POST_FA(CNT_POST_FA)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .fs_pulse_i(fs_pulse), .fa_done_i(fa_done),
    .fa_trig_o(fa_trig), .dly_strb_o(dly_strb), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
    .rd_addr_o(rd_addr), .chn_cnt_o(chn_cnt), .busy_o(busy), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every strobe must match the next queued channel write.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (dly_strb === 1'b1 || wr_en === 1'b1)) begin
      chk("wr_en_eq_strb", int'(wr_en), int'(dly_strb));
      if (exp_addr_q.size() == 0) chk("strb_unexpected", int'(wr_addr), -1);
      else chk("wr_addr", int'(wr_addr), exp_addr_q.pop_front());
    end
  end

  // Caller sets fs_pulse (or is in a non-final NEXT); first step enters PRE for channel ch.
  task automatic step_to_trig(input int ch);
    int n;
    step();
    fs_pulse = 1'b0;
    chk("pre_chn", int'(chn_cnt), ch);
    chk("pre_err", int'(error), exp_err);
    n = 1;
    while (fa_trig !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("trig_latency", n, CNT_PRE_FA + 1);
  endtask

  // Starts in the fa_trig cycle; done_at is the WAIT_FA cycle with fa_done (0 = never).
  task automatic run_chan(input int ch, input int done_at);
    chk("trig_rd_addr", int'(rd_addr), ch);
    exp_addr_q.push_back(ch);
    for (int k = 1; k <= CNT_POST_FA; k++) begin
      step();
      fa_done = (k == done_at);
      if (k == done_at || k == CNT_POST_FA) break;
    end
    if (done_at == 0) exp_err = 1;
    step();
    fa_done = 1'b0;
    chk("strb", int'(dly_strb), 1);
    chk("strb_err", int'(error), exp_err);
    step();
  endtask

  task automatic finish_frame();
    step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_chn", int'(chn_cnt), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_err = 0;
    chk("rst_err", int'(error), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; fs_pulse = 1'b0; fa_done = 1'b0;
    // Reset held with fs toggling
    for (int i = 0; i < 5; i++) begin
      fs_pulse = ~fs_pulse;
      step();
    end
    fs_pulse = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_trig", int'(fa_trig), 0);
    chk("rst_strb", int'(dly_strb) + int'(wr_en), 0);
    chk("rst_addr", int'(chn_cnt) + int'(rd_addr) + int'(wr_addr), 0);
    chk("rst_error", int'(error), 0);
    reset_n = 1'b1;
    step();
    chk("post_rst_busy", int'(busy), 0);

    // Nominal frame
    fs_pulse = 1'b1;
    step_to_trig(0);
    run_chan(0, 2);
    step_to_trig(1);
    run_chan(1, 2);
    finish_frame();
    chk("nom_error", int'(error), 0);

    // FA timeout on both channels
    fs_pulse = 1'b1;
    step_to_trig(0);
    run_chan(0, 0);
    step_to_trig(1);
    run_chan(1, 0);
    finish_frame();
    chk("to_error", int'(error), 1);
    do_reset();

    // Overrun during channel 1 WAIT_FA
    fs_pulse = 1'b1;
    step_to_trig(0);
    run_chan(0, 2);
    step_to_trig(1);
    step();
    step();
    fs_pulse = 1'b1;
    exp_err = 1;
    step_to_trig(0);
    chk("ovr_error", int'(error), 1);
    run_chan(0, 1);
    step_to_trig(1);
    run_chan(1, 1);
    finish_frame();
    do_reset();

    // fa_done in terminal cycle, then fs on final NEXT
    fs_pulse = 1'b1;
    step_to_trig(0);
    run_chan(0, CNT_POST_FA);
    step_to_trig(1);
    run_chan(1, CNT_POST_FA);
    fs_pulse = 1'b1;
    step_to_trig(0);
    chk("race_busy", int'(busy), 1);
    run_chan(0, 3);
    step_to_trig(1);
    run_chan(1, 3);
    finish_frame();
    chk("race_error", int'(error), 0);

    // fa_done while idle is ignored
    fa_done = 1'b1;
    step();
    step();
    fa_done = 1'b0;
    chk("idle_done_busy", int'(busy), 0);

    // Reset in WAIT_FA
    fs_pulse = 1'b1;
    step_to_trig(0);
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_wr_en", int'(wr_en), 0);
    step();
    step();
    chk("midrst_wr_en2", int'(wr_en), 0);
    fs_pulse = 1'b1;
    step_to_trig(0);
    run_chan(0, 1);
    step_to_trig(1);
    run_chan(1, 1);
    finish_frame();
    chk("midrst_error", int'(error), 0);

    step();
    chk("sb_empty", exp_addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
